// File: rtl/uart_rx_fifo_csr_pkg.sv
// Shared types and constants for the UART RX byte FIFO and its CSR interface.
// CSR address/operation types, the CSR address map, the default FIFO depth
// and the head-register FSM encoding.
package uart_rx_fifo_csr_pkg;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_t;

    localparam CsrAddrT RxFifoByteCsrAddr = 12'h7C4;
    localparam CsrAddrT RxFifoStatCsrAddr = 12'h7C5;
    localparam CsrAddrT RxFifoThrCsrAddr  = 12'h7C6;

    localparam int RxFifoDepthBits = 4;

    // Head register state: empty, waiting on the RAM read, or holding a byte.
    typedef enum logic [1:0] {
        HEAD_IDLE  = 2'd0,
        HEAD_FETCH = 2'd1,
        HEAD_HOLD  = 2'd2
    } head_state_t;

    // Only a plain read pops the byte CSR; set/clear/write never consume data.
    function automatic logic is_read_op(input csr_op_t op);
        return op == CSR_OP_READ;
    endfunction

endpackage

// File: rtl/sdpram_block.sv
// Simple dual-port RAM: one write port, one read port, 1-cycle synchronous
// read. A read and a write to the same address in the same cycle return the
// old contents (read-first). Contents are not reset.
module sdpram_block #(
    parameter int FifoSizeBits = 128,
    parameter int WordBits     = 8,
    localparam int Words       = FifoSizeBits / WordBits,
    localparam int AddrBits    = $clog2(Words)
) (
    input  logic                clk_i,
    input  logic                wr_en,
    input  logic [AddrBits-1:0] wr_addr,
    input  logic [WordBits-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AddrBits-1:0] rd_addr,
    output logic [WordBits-1:0] rd_data
);

    logic [WordBits-1:0] mem [Words];

    // Storage write and registered read share one clocked process.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo_csr.sv
// UART receive byte FIFO with CSR read-out.
// Bytes from the UART deserializer land in an sdpram_block; the oldest byte
// sits in a head register that the byte CSR exposes and a byte CSR read pops.
// An empty FIFO bypasses the RAM so a lone byte is visible the next cycle.
// Optional feature macro: UART_RX_FIFO_IRQ_EN adds a level threshold CSR and
// a registered irq output.
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte
// offered while all 2**DepthBits+1 slots are taken is dropped and flagged in
// the sticky overflow bit. A pop happens on any cycle with csr_enable=1,
// csr_addr=byte CSR, csr_op=read and have_data=1; otherwise nothing changes.
module uart_rx_fifo_csr
    import uart_rx_fifo_csr_pkg::*;
#(
    parameter int DepthBits   = RxFifoDepthBits,
    parameter int RamSizeBits = (2**DepthBits) * 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        csr_enable,
    input  CsrAddrT     csr_addr,
    input  csr_op_t     csr_op,
    input  word         rs1_data,
    output word         csr_data_out,
    output logic        have_data,
    output logic        overflow,
`ifdef UART_RX_FIFO_IRQ_EN
    output logic        irq,
`endif
    output head_state_t head_state
);

    typedef logic [DepthBits-1:0] RxFifoPtrT;
    typedef logic [DepthBits:0]   RxFifoCntT;

    localparam RxFifoCntT DepthCnt = RxFifoCntT'(2**DepthBits);

    head_state_t state_q, state_d;
    RxFifoPtrT   wr_ptr_q, rd_ptr_q;
    RxFifoCntT   count_q, count_d;
    RxFifoCntT   level;
    logic [7:0]  head_q;
    logic        head_valid_q;
    logic        overflow_q;
    logic [7:0]  spram_dout;

    logic pop, rd_issue, fetch_done, bypass;
    logic ram_space, ram_push, drop, ovf_clear, full;
    logic unused_rs1;

    assign pop = csr_enable && (csr_addr == RxFifoByteCsrAddr)
                 && is_read_op(csr_op) && head_valid_q;

    assign ovf_clear = csr_enable && (csr_addr == RxFifoStatCsrAddr)
                       && ((csr_op == CSR_OP_WRITE) || (csr_op == CSR_OP_CLEAR))
                       && rs1_data[16];

    // count is at most DepthCnt+1 only in FETCH after a push+pop at full.
    assign full  = (count_q >= DepthCnt);
    assign level = count_q + RxFifoCntT'(head_valid_q);

    // A slot frees up when the read of the oldest RAM entry is issued this
    // cycle (read-first RAM) or has already been captured in FETCH.
    assign ram_space = (count_q < DepthCnt)
                       || ((count_q == DepthCnt) && (rd_issue || (state_q == HEAD_FETCH)));
    assign ram_push  = rx_valid && !bypass && ram_space;
    assign drop      = rx_valid && !bypass && !ram_space;

    assign count_d = count_q + RxFifoCntT'(ram_push) - RxFifoCntT'(fetch_done);

    assign have_data  = head_valid_q;
    assign overflow   = overflow_q;
    assign head_state = state_q;

    assign unused_rs1 = ^{rs1_data[31:17], rs1_data[15:0]};

    sdpram_block #(
        .FifoSizeBits(RamSizeBits),
        .WordBits    (8)
    ) u_ram (
        .clk_i  (clk_i),
        .wr_en  (ram_push),
        .wr_addr(wr_ptr_q),
        .wr_data(rx_data),
        .rd_en  (rd_issue),
        .rd_addr(rd_ptr_q),
        .rd_data(spram_dout)
    );

    // Head FSM next state: refill from RAM when it holds data, else bypass.
    always_comb begin
        state_d    = state_q;
        rd_issue   = 1'b0;
        fetch_done = 1'b0;
        bypass     = 1'b0;
        case (state_q)
            HEAD_IDLE: begin
                if (count_q != '0) begin
                    rd_issue = 1'b1;
                    state_d  = HEAD_FETCH;
                end else if (rx_valid) begin
                    bypass  = 1'b1;
                    state_d = HEAD_HOLD;
                end
            end
            HEAD_FETCH: begin
                fetch_done = 1'b1;
                state_d    = HEAD_HOLD;
            end
            HEAD_HOLD: begin
                if (pop) begin
                    if (count_q != '0) begin
                        rd_issue = 1'b1;
                        state_d  = HEAD_FETCH;
                    end else if (rx_valid) begin
                        bypass  = 1'b1;
                        state_d = HEAD_HOLD;
                    end else begin
                        state_d = HEAD_IDLE;
                    end
                end
            end
            default: state_d = HEAD_IDLE;
        endcase
    end

    // FIFO state: FSM register, pointers, RAM count, head byte and overflow.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= HEAD_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            head_valid_q <= (state_d == HEAD_HOLD);
            if (ram_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fetch_done) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bypass) begin
                head_q <= rx_data;
            end else if (fetch_done) begin
                head_q <= spram_dout;
            end
            // A drop in the same cycle as a clear leaves overflow set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    RxFifoCntT thr_q;
    logic      irq_q;
    logic      thr_wr;

    assign thr_wr = csr_enable && (csr_addr == RxFifoThrCsrAddr);
    assign irq    = irq_q;

    // Threshold CSR update and registered level/overflow interrupt.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            thr_q <= RxFifoCntT'(1);
            irq_q <= 1'b0;
        end else begin
            if (thr_wr) begin
                case (csr_op)
                    CSR_OP_WRITE: thr_q <= rs1_data[DepthBits:0];
                    CSR_OP_SET:   thr_q <= thr_q | rs1_data[DepthBits:0];
                    CSR_OP_CLEAR: thr_q <= thr_q & ~rs1_data[DepthBits:0];
                    default:      thr_q <= thr_q;
                endcase
            end
            irq_q <= (level >= thr_q) | overflow_q;
        end
    end
`endif

    // CSR read mux; unknown addresses and an empty head read as zero.
    always_comb begin
        csr_data_out = '0;
        case (csr_addr)
            RxFifoByteCsrAddr: begin
                if (head_valid_q) begin
                    csr_data_out = {23'b0, 1'b1, head_q};
                end
            end
            RxFifoStatCsrAddr: begin
                csr_data_out[DepthBits:0] = level;
                csr_data_out[16]          = overflow_q;
                csr_data_out[17]          = full;
            end
`ifdef UART_RX_FIFO_IRQ_EN
            RxFifoThrCsrAddr: begin
                csr_data_out[DepthBits:0] = thr_q;
            end
`endif
            default: csr_data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fifo_csr.sv
// Bench for uart_rx_fifo_csr (default depth, 17-byte capacity).
// Define UART_RX_FIFO_IRQ_EN to also exercise the threshold/irq path.
module tb_uart_rx_fifo_csr;
    import uart_rx_fifo_csr_pkg::*;

    localparam int Capacity = 17;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        csr_enable;
    CsrAddrT     csr_addr;
    csr_op_t     csr_op;
    word         rs1_data;
    word         csr_data_out;
    logic        have_data;
    logic        overflow;
`ifdef UART_RX_FIFO_IRQ_EN
    logic        irq;
`endif
    head_state_t head_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic       exp_overflow;
    word        dummy;

    uart_rx_fifo_csr dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .csr_enable  (csr_enable),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .rs1_data    (rs1_data),
        .csr_data_out(csr_data_out),
        .have_data   (have_data),
        .overflow    (overflow),
`ifdef UART_RX_FIFO_IRQ_EN
        .irq         (irq),
`endif
        .head_state  (head_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk_i);
        reset_ni   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        csr_enable = 1'b0;
        csr_addr   = RxFifoStatCsrAddr;
        csr_op     = CSR_OP_READ;
        rs1_data   = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        exp_q.delete();
        exp_overflow = 1'b0;
    endtask

    // ---------------- model ----------------
    function automatic word exp_stat();
        word s = '0;
        int  lvl = exp_q.size();
        s[4:0] = lvl[4:0];
        s[16]  = exp_overflow;
        s[17]  = (lvl == Capacity);
        return s;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (exp_q.size() < Capacity) exp_q.push_back(b);
        else exp_overflow = 1'b1;
    endfunction

    // ---------------- drivers ----------------
    // One clock cycle of stimulus; rd is csr_data_out sampled mid-cycle.
    task automatic cycle(input logic push, input logic [7:0] b, input logic en,
                         input CsrAddrT addr, input csr_op_t op, input word wdata,
                         output word rd);
        @(negedge clk_i);
        rx_valid   = push;
        rx_data    = b;
        csr_enable = en;
        csr_addr   = addr;
        csr_op     = op;
        rs1_data   = wdata;
        #1 rd = csr_data_out;
        @(posedge clk_i);
        #1;
        rx_valid   = 1'b0;
        csr_enable = 1'b0;
        csr_op     = CSR_OP_READ;
        rs1_data   = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        model_push(b);
        cycle(1'b1, b, 1'b0, RxFifoStatCsrAddr, CSR_OP_READ, '0, dummy);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, RxFifoStatCsrAddr, CSR_OP_READ, '0, dummy);
    endtask

    task automatic read_csr(input CsrAddrT addr, output word rd);
        cycle(1'b0, 8'h00, 1'b1, addr, CSR_OP_READ, '0, rd);
    endtask

    task automatic wait_head(output bit ok);
        int n = 0;
        while (have_data !== 1'b1 && n < 8) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        ok = (have_data === 1'b1);
    endtask

    // Pop the head (optionally pushing b in the same cycle) and score it.
    task automatic pop_check(input string name, input logic also_push, input logic [7:0] b);
        word rd;
        word exp;
        bit  ok;
        wait_head(ok);
        tests_run++;
        if (!ok || exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: no head byte, have_data=%b expected entries=%0d",
                     name, have_data, exp_q.size());
            exp_q.delete();
        end else begin
            exp = {23'b0, 1'b1, exp_q.pop_front()};
            if (also_push) exp_q.push_back(b);
            cycle(also_push, b, 1'b1, RxFifoByteCsrAddr, CSR_OP_READ, '0, rd);
            if (rd !== exp) begin
                tests_failed++;
                $display("FAIL %s: byte csr got %08h expected %08h", name, rd, exp);
            end
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_check(name, 1'b0, 8'h00);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        word rd;
        @(negedge clk_i);
        reset_ni = 1'b0;
        csr_addr = RxFifoStatCsrAddr;
        #1;
        tests_run++;
        if (have_data !== 1'b0 || overflow !== 1'b0 || csr_data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: have_data=%b overflow=%b csr=%08h expected 0 0 00000000",
                     have_data, overflow, csr_data_out);
        end
        do_reset();
        tests_run++;
        if (head_state !== HEAD_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", head_state, HEAD_IDLE);
        end
        read_csr(RxFifoByteCsrAddr, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_byte_csr: got %08h expected 00000000", rd);
        end
        read_csr(12'h123, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL foreign_addr: got %08h expected 00000000", rd);
        end
    endtask

    task automatic test_single();
        word rd;
        push_byte(8'h41);
        tests_run++;
        if (have_data !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass_latency: have_data=%b expected 1", have_data);
        end
        cycle(1'b0, 8'h00, 1'b1, RxFifoByteCsrAddr, CSR_OP_WRITE, 32'hFFFF_FFFF, dummy);
        read_csr(RxFifoStatCsrAddr, rd);
        tests_run++;
        if (rd !== exp_stat()) begin
            tests_failed++;
            $display("FAIL byte_write_ignored: status got %08h expected %08h", rd, exp_stat());
        end
        pop_check("single_pop", 1'b0, 8'h00);
        tests_run++;
        if (have_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after_pop: have_data=%b expected 0", have_data);
        end
    endtask

    task automatic test_back_to_back();
        word rd;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
        for (int i = 0; i < 5; i++) begin
            read_csr(RxFifoStatCsrAddr, rd);
            tests_run++;
            if (rd !== exp_stat()) begin
                tests_failed++;
                $display("FAIL burst_status_%0d: got %08h expected %08h", i, rd, exp_stat());
            end
            pop_check("burst_pop", 1'b0, 8'h00);
            if (i == 0) begin
                tests_run++;
                if (have_data !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL refill_gap: have_data=%b expected 0", have_data);
                end
                @(posedge clk_i);
                #1;
                tests_run++;
                if (have_data !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL refill_latency: have_data=%b expected 1", have_data);
                end
            end
            idle(2);
        end
        read_csr(RxFifoStatCsrAddr, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL burst_status_end: got %08h expected 00000000", rd);
        end
    endtask

    task automatic test_overflow();
        word rd;
        for (int i = 0; i < 18; i++) push_byte(8'(8'h60 + i));
        read_csr(RxFifoStatCsrAddr, rd);
        tests_run++;
        if (overflow !== 1'b1 || rd !== exp_stat()) begin
            tests_failed++;
            $display("FAIL overflow_set: overflow=%b status=%08h expected 1 %08h",
                     overflow, rd, exp_stat());
        end
        cycle(1'b0, 8'h00, 1'b1, RxFifoStatCsrAddr, CSR_OP_WRITE, 32'h0001_0000, dummy);
        exp_overflow = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: overflow=%b expected 0", overflow);
        end
        // Drop and clear in the same cycle: the drop must win.
        model_push(8'hEE);
        cycle(1'b1, 8'hEE, 1'b1, RxFifoStatCsrAddr, CSR_OP_CLEAR, 32'h0001_0000, dummy);
        tests_run++;
        if (overflow !== exp_overflow) begin
            tests_failed++;
            $display("FAIL drop_beats_clear: overflow=%b expected %b", overflow, exp_overflow);
        end
        cycle(1'b0, 8'h00, 1'b1, RxFifoStatCsrAddr, CSR_OP_WRITE, 32'h0001_0000, dummy);
        exp_overflow = 1'b0;
        drain("overflow_drain");
        read_csr(RxFifoStatCsrAddr, rd);
        tests_run++;
        if (rd !== exp_stat()) begin
            tests_failed++;
            $display("FAIL overflow_drained: status got %08h expected %08h", rd, exp_stat());
        end
    endtask

    task automatic test_full_push_pop();
        word rd;
        for (int i = 0; i < Capacity; i++) push_byte(8'(8'h80 + i));
        for (int i = 0; i < 20; i++) begin
            pop_check("full_push_pop", 1'b1, 8'(8'hC0 + i));
            read_csr(RxFifoStatCsrAddr, rd);
            tests_run++;
            if (overflow !== 1'b0 || rd !== exp_stat()) begin
                tests_failed++;
                $display("FAIL full_level_%0d: overflow=%b status=%08h expected 0 %08h",
                         i, overflow, rd, exp_stat());
            end
        end
        drain("wrap_drain");
    endtask

    task automatic test_empty_and_reset();
        word rd;
        read_csr(RxFifoByteCsrAddr, rd);
        tests_run++;
        if (rd !== 32'h0 || have_data !== 1'b0 || head_state !== HEAD_IDLE) begin
            tests_failed++;
            $display("FAIL empty_pop: csr=%08h have_data=%b state=%0d expected 00000000 0 %0d",
                     rd, have_data, head_state, HEAD_IDLE);
        end
        push_byte(8'h5A);
        push_byte(8'h5B);
        drain("after_empty_pop");
        for (int i = 0; i < 18; i++) push_byte(8'(8'hA0 + i));
        tests_run++;
        if (overflow !== exp_overflow) begin
            tests_failed++;
            $display("FAIL pre_reset_overflow: overflow=%b expected %b", overflow, exp_overflow);
        end
        @(negedge clk_i);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        csr_addr = RxFifoStatCsrAddr;
        #2 reset_ni = 1'b0;
        #1;
        tests_run++;
        if (have_data !== 1'b0 || overflow !== 1'b0 || csr_data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: have_data=%b overflow=%b status=%08h expected 0 0 00000000",
                     have_data, overflow, csr_data_out);
        end
        csr_addr = RxFifoByteCsrAddr;
        #1;
        tests_run++;
        if (csr_data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset_byte: got %08h expected 00000000", csr_data_out);
        end
        rx_valid = 1'b0;
        do_reset();
        push_byte(8'h33);
        drain("after_reset");
    endtask

`ifdef UART_RX_FIFO_IRQ_EN
    task automatic test_irq();
        word rd;
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, RxFifoThrCsrAddr, CSR_OP_WRITE, 32'h3, dummy);
        read_csr(RxFifoThrCsrAddr, rd);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++;
            $display("FAIL thr_readback: got %08h expected 00000003", rd);
        end
        push_byte(8'h01);
        push_byte(8'h02);
        idle(3);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_below_thr: irq=%b expected 0", irq);
        end
        push_byte(8'h03);
        idle(3);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_at_thr: irq=%b expected 1", irq);
        end
        pop_check("irq_pop", 1'b0, 8'h00);
        idle(3);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_after_pop: irq=%b expected 0", irq);
        end
        drain("irq_drain");
    endtask
`else
    task automatic test_irq();
        word rd;
        read_csr(RxFifoThrCsrAddr, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL thr_absent: got %08h expected 00000000", rd);
        end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        reset_ni     = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        csr_enable   = 1'b0;
        csr_addr     = RxFifoStatCsrAddr;
        csr_op       = CSR_OP_READ;
        rs1_data     = '0;
        exp_overflow = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_empty_and_reset();
        test_irq();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
